// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and coordinate type for the timing
// generator and the renderers that bounds-check against it.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam bit VGA_H_POL = 1'b0;
    localparam bit VGA_V_POL = 1'b0;

    typedef logic [9:0] coord_t;

    // Half-open range test done in 11 bits so an upper bound of 1024 still works.
    function automatic logic in_span(input coord_t v, input int lo, input int hi);
        return ({1'b0, v} >= 11'(lo)) && ({1'b0, v} < 11'(hi));
    endfunction

endpackage

// File: rtl/vga_pix_ce_div.sv
// Pixel-rate enable: a modulo-CLK_DIV counter whose terminal count is pix_ce.
module vga_pix_ce_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_ce
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
        end else if (div_cnt_reg == LAST) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // With CLK_DIV = 1 the counter never leaves zero, so pix_ce stays high.
    assign pix_ce = (div_cnt_reg == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters with same-edge registered decode of blanking, sync and
// line/frame markers, advanced once per pixel-clock enable.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit H_POL    = VGA_H_POL,
    parameter bit V_POL    = VGA_V_POL
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_ce,
    output logic [9:0] px,
    output logic [9:0] py,
    output logic       video_active,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO   = H_ACTIVE + H_FP;
    localparam int VS_LO   = V_ACTIVE + V_FP;
    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    if (H_TOTAL > 1024) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    vga_pix_ce_div #(
        .CLK_DIV(CLK_DIV)
    ) u_pix_ce_div (
        .clk   (clk),
        .rst   (rst),
        .pix_ce(pix_ce)
    );

    coord_t px_reg, py_reg;
    coord_t px_next, py_next;
    logic   px_wrap;
    logic   active_reg, hsync_reg, vsync_reg, line_reg, frame_reg;

    always_comb begin
        px_wrap = (px_reg == H_LAST);
        px_next = px_wrap ? '0 : px_reg + 1'b1;
        py_next = py_reg;
        if (px_wrap) begin
            py_next = (py_reg == V_LAST) ? '0 : py_reg + 1'b1;
        end
    end

    // Flags decode from the next coordinates so they land with px/py on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            px_reg     <= H_LAST;
            py_reg     <= V_LAST;
            active_reg <= 1'b0;
            hsync_reg  <= ~H_POL;
            vsync_reg  <= ~V_POL;
            line_reg   <= 1'b0;
            frame_reg  <= 1'b0;
        end else if (pix_ce) begin
            px_reg     <= px_next;
            py_reg     <= py_next;
            active_reg <= in_span(px_next, 0, H_ACTIVE) && in_span(py_next, 0, V_ACTIVE);
            hsync_reg  <= in_span(px_next, HS_LO, HS_LO + H_SYNC) ? H_POL : ~H_POL;
            vsync_reg  <= in_span(py_next, VS_LO, VS_LO + V_SYNC) ? V_POL : ~V_POL;
            line_reg   <= (px_next == '0);
            frame_reg  <= (px_next == '0) && (py_next == '0);
        end
    end

    assign px           = px_reg;
    assign py           = py_reg;
    assign video_active = active_reg;
    assign hsync        = hsync_reg;
    assign vsync        = vsync_reg;
    assign line_start   = line_reg;
    assign frame_start  = frame_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three timing generators (default 640x480, a small CLK_DIV=1 active-high one,
// a small CLK_DIV=3 one) compared every clk against an arithmetic raster model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

    logic       ce_a, va_a, hs_a, vs_a, ls_a, fs_a;
    logic [9:0] px_a, py_a;
    logic       ce_b, va_b, hs_b, vs_b, ls_b, fs_b;
    logic [9:0] px_b, py_b;
    logic       ce_c, va_c, hs_c, vs_c, ls_c, fs_c;
    logic [9:0] px_c, py_c;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .pix_ce(ce_a), .px(px_a), .py(py_a),
        .video_active(va_a), .hsync(hs_a), .vsync(vs_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(4), .H_POL(1'b1), .V_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pix_ce(ce_b), .px(px_b), .py(py_b),
        .video_active(va_b), .hsync(hs_b), .vsync(vs_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .H_POL(1'b0), .V_POL(1'b0)
    ) dut_c (
        .clk(clk), .rst(rst_c), .pix_ce(ce_c), .px(px_c), .py(py_c),
        .video_active(va_c), .hsync(hs_c), .vsync(vs_c),
        .line_start(ls_c), .frame_start(fs_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // k = clk edges since the last edge that saw rst high. After k edges the
    // raster has taken k/cd steps; step n lands on pixel index n-1 of the frame.
    task automatic check_inst(
        input string name, input int k, input int cd,
        input int ha, input int hf, input int hsw, input int hb,
        input int va, input int vf, input int vsw, input int vb,
        input bit hp, input bit vp,
        input logic ce, input logic [9:0] x, input logic [9:0] y,
        input logic act, input logic hs, input logic vs, input logic ls, input logic fs,
        output int ex, output int ey);
        int ht, vt, n, idx;
        logic e_ce, e_act, e_hs, e_vs, e_ls, e_fs;
        ht   = ha + hf + hsw + hb;
        vt   = va + vf + vsw + vb;
        n    = k / cd;
        e_ce = ((k % cd) == cd - 1);
        if (n == 0) begin
            ex = ht - 1; ey = vt - 1;
            e_act = 1'b0; e_hs = ~hp; e_vs = ~vp; e_ls = 1'b0; e_fs = 1'b0;
        end else begin
            idx   = (n - 1) % (ht * vt);
            ex    = idx % ht;
            ey    = idx / ht;
            e_act = (ex < ha) && (ey < va);
            e_hs  = (ex >= ha + hf && ex < ha + hf + hsw) ? hp : ~hp;
            e_vs  = (ey >= va + vf && ey < va + vf + vsw) ? vp : ~vp;
            e_ls  = (ex == 0);
            e_fs  = (ex == 0) && (ey == 0);
        end
        check({name, ".pix_ce"},       32'(ce),  32'(e_ce));
        check({name, ".px"},           32'(x),   32'(ex));
        check({name, ".py"},           32'(y),   32'(ey));
        check({name, ".video_active"}, 32'(act), 32'(e_act));
        check({name, ".hsync"},        32'(hs),  32'(e_hs));
        check({name, ".vsync"},        32'(vs),  32'(e_vs));
        check({name, ".line_start"},   32'(ls),  32'(e_ls));
        check({name, ".frame_start"},  32'(fs),  32'(e_fs));
    endtask

    initial begin
        int k_a = 0, k_b = 0, k_c = 0;
        int xa, ya, xb, yb, xc, yc;
        bit a_mid_done = 1'b0;
        @(posedge clk);
        for (int cyc = 0; cyc < 12000; cyc++) begin
            @(negedge clk);
            k_a = rst_a ? 0 : k_a + 1;
            k_b = rst_b ? 0 : k_b + 1;
            k_c = rst_c ? 0 : k_c + 1;

            check_inst("a", k_a, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
                       ce_a, px_a, py_a, va_a, hs_a, vs_a, ls_a, fs_a, xa, ya);
            check_inst("b", k_b, 1, 20, 3, 5, 4, 12, 2, 3, 4, 1'b1, 1'b1,
                       ce_b, px_b, py_b, va_b, hs_b, vs_b, ls_b, fs_b, xb, yb);
            check_inst("c", k_c, 3, 40, 4, 6, 6, 8, 1, 2, 2, 1'b0, 1'b0,
                       ce_c, px_c, py_c, va_c, hs_c, vs_c, ls_c, fs_c, xc, yc);

            // Default instance: release after 3 clks, then one 1-clk reset mid-line.
            if (rst_a) begin
                if (cyc >= 2) begin
                    rst_a = 1'b0;
                    $display("reset release a at cycle %0d", cyc);
                end
            end else if (!a_mid_done && xa == 300 && ya == 1) begin
                rst_a = 1'b1;
                a_mid_done = 1'b1;
                $display("mid-frame reset a at px=%0d py=%0d cycle %0d", xa, ya, cyc);
            end

            if (rst_b) begin
                rst_b = ($urandom_range(0, 3) == 0);
                if (!rst_b) $display("reset release b at cycle %0d", cyc);
            end else begin
                rst_b = ($urandom_range(0, 1499) == 0);
                if (rst_b) $display("reset assert b at px=%0d py=%0d cycle %0d", xb, yb, cyc);
            end

            if (rst_c) begin
                rst_c = ($urandom_range(0, 3) == 0);
                if (!rst_c) $display("reset release c at cycle %0d", cyc);
            end else begin
                rst_c = ($urandom_range(0, 1999) == 0);
                if (rst_c) $display("reset assert c at px=%0d py=%0d cycle %0d", xc, yc, cyc);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
